// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the counter_arbiter slice.
//   arb_state_t        : burst FSM state encoding
//   MODE_UP/MODE_DOWN  : direction encoding on req_mode/mode
//   DEF_*              : default parameter values
//   wrap_inc()         : modulo-n increment used for the round-robin pointer
package counter_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_LEN_W   = 4;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // (v + 1) mod n, for v < n
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Bus between the requesting clients and counter_arbiter.
//   req/req_mode/req_len : per-requester request, direction and step count
//   grant/done           : one-hot owner and completion pulse
//   busy/mode/step/count : shared counter status
// Modports: master = client side, slave = arbiter side.
interface counter_arbiter_if #(
    parameter int unsigned NUM_REQ = counter_arb_pkg::DEF_NUM_REQ,
    parameter int unsigned WIDTH   = counter_arb_pkg::DEF_WIDTH,
    parameter int unsigned LEN_W   = counter_arb_pkg::DEF_LEN_W
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_mode;
    logic [NUM_REQ-1:0][LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic                          busy;
    logic                          mode;
    logic                          step;
    logic [WIDTH-1:0]              count;

    modport master (
        output req, req_mode, req_len,
        input  grant, done, busy, mode, step, count
    );

    modport slave (
        input  req, req_mode, req_len,
        output grant, done, busy, mode, step, count
    );

endinterface

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches req_i starting at ptr_i and
// wrapping, returns the first requester found.
//   req_i   : request vector
//   ptr_i   : index where the search starts
//   gnt_o   : one-hot winner
//   idx_o   : winner index
//   valid_o : any request present
module rr_arbiter
    import counter_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned cand;

    // First request at or after ptr_i wins
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o            = 1'b1;
                gnt_o[IDX_W'(cand)] = 1'b1;
                idx_o              = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Shares one up/down count register among NUM_REQ requesters. A round-robin
// winner owns the counter for a burst of req_len steps in direction req_mode,
// one step per cycle; done pulses to the owner at the end.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : counter_arbiter_if.slave (req/req_mode/req_len in;
//                grant/done/busy/mode/step/count out, all registered)
// Build option: COUNTER_ARB_SATURATE_EN makes the count saturate at the
// range limits instead of wrapping; burst timing is unchanged.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    counter_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               mode_q, mode_d;
    logic               step_q, step_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [WIDTH-1:0]   count_step;
    logic [IDX_W-1:0]   ptr_after_owner;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Count value after one step in the current direction
    always_comb begin
        count_step = count_q;
`ifdef COUNTER_ARB_SATURATE_EN
        if (mode_q == MODE_UP) begin
            count_step = (count_q == {WIDTH{1'b1}}) ? count_q : count_q + WIDTH'(1);
        end else begin
            count_step = (count_q == '0) ? count_q : count_q - WIDTH'(1);
        end
`else
        count_step = (mode_q == MODE_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
`endif
    end

    assign ptr_after_owner = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            mode_q   <= MODE_UP;
            step_q   <= 1'b0;
            count_q  <= '0;
            rem_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            mode_q   <= mode_d;
            step_q   <= step_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next state; registered outputs are computed for the state being entered
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        mode_d   = mode_q;
        step_d   = 1'b0;
        count_d  = count_q;
        rem_d    = rem_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (arb_valid) begin
                    state_d = GRANT;
                    grant_d = arb_gnt;
                    busy_d  = 1'b1;
                    owner_d = arb_idx;
                    mode_d  = bus.req_mode[arb_idx];
                    rem_d   = bus.req_len[arb_idx];
                end
            end

            GRANT, RUN: begin
                if (!bus.req[owner_q]) begin
                    // Owner abandoned: release without done, still rotate past it
                    state_d  = IDLE;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = ptr_after_owner;
                end else if (rem_q == '0) begin
                    state_d         = DONE;
                    grant_d         = '0;
                    busy_d          = 1'b0;
                    done_d[owner_q] = 1'b1;
                end else begin
                    state_d = RUN;
                    step_d  = 1'b1;
                    count_d = count_step;
                    rem_d   = rem_q - LEN_W'(1);
                end
            end

            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = ptr_after_owner;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.mode  = mode_q;
    assign bus.step  = step_q;
    assign bus.count = count_q;

endmodule
